// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Bundles the qualifier inputs and the staged reset outputs of the
//   reset sequencer so the top of each lab design can pass them around
//   as one object.
//   Signals:
//     Lock_i  clock-ready qualifier (e.g. PLL lock)
//     Req_i   soft reset request, level-sensitive
//     Rst_o   per-domain active-high resets, bit 0 released first
//     Busy_o  high while any Rst_o bit is asserted
//     Done_o  one-cycle pulse when the last bit releases
//   Modports:
//     master  drives the qualifiers, observes the resets
//     slave   the sequencer itself
interface reset_sequencer_if #(
    parameter int N_OUT = 3
) ();
    logic             Lock_i;
    logic             Req_i;
    logic [N_OUT-1:0] Rst_o;
    logic             Busy_o;
    logic             Done_o;

    modport master (
        output Lock_i,
        output Req_i,
        input  Rst_o,
        input  Busy_o,
        input  Done_o
    );

    modport slave (
        input  Lock_i,
        input  Req_i,
        output Rst_o,
        output Busy_o,
        output Done_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Stretches a synchronous reset for HOLD_CYCLES qualifying edges, then
//   releases N_OUT downstream reset domains one at a time, STAGE_GAP
//   cycles apart, and pulses Done_o when the last one drops. A qualifying
//   edge is one with Lock_i=1 and Req_i=0; any non-qualifying edge outside
//   HOLD aborts back to HOLD with every output re-asserted.
//   Ports:
//     Clk   system clock, all logic on posedge
//     Rst   synchronous active-high reset
//     bus   reset_sequencer_if.slave (Lock_i, Req_i in; Rst_o, Busy_o,
//           Done_o out, all outputs registered)
module reset_sequencer #(
    parameter int N_OUT       = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    reset_sequencer_if.slave   bus
);
    // stage must be able to hold N_OUT (one past the last index)
    localparam int STG_W = (N_OUT < 2) ? 1 : $clog2(N_OUT + 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [STG_W-1:0] r_stage, w_stage_nxt;
    logic [N_OUT-1:0] r_rst_o, w_rst_o_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_qual;

    assign w_qual = bus.Lock_i & ~bus.Req_i;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_stage <= '0;
            r_rst_o <= '1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
            r_rst_o <= w_rst_o_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        w_rst_o_nxt = r_rst_o;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_HOLD: begin
                w_rst_o_nxt = '1;
                w_busy_nxt  = 1'b1;
                w_stage_nxt = '0;
                if (!w_qual) begin
                    // any lost lock / soft request restarts the hold fully
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_cnt_nxt      = '0;
                    w_rst_o_nxt[0] = 1'b0;
                    w_stage_nxt    = STG_W'(1);
                    if (N_OUT == 1) begin
                        w_state_nxt = S_RUN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RELEASE: begin
                if (!w_qual) begin
                    // abort wins over a release due on this same edge
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                    w_rst_o_nxt = '1;
                    w_busy_nxt  = 1'b1;
                end else if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                    w_cnt_nxt   = '0;
                    w_stage_nxt = r_stage + 1'b1;
                    // decoded clear avoids a variable index wider than Rst_o
                    for (int i = 0; i < N_OUT; i++) begin
                        if (STG_W'(i) == r_stage) w_rst_o_nxt[i] = 1'b0;
                    end
                    if (r_stage == STG_W'(N_OUT - 1)) begin
                        w_state_nxt = S_RUN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RUN: begin
                if (!w_qual) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                    w_rst_o_nxt = '1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_rst_o_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
                w_stage_nxt = '0;
                w_rst_o_nxt = '1;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    assign bus.Rst_o  = r_rst_o;
    assign bus.Busy_o = r_busy;
    assign bus.Done_o = r_done;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed checks of the reset sequencer at default parameters plus a
//   second instance at the N_OUT=1 / HOLD=1 / GAP=1 corner. Edge numbers
//   count posedges after the last edge that sampled Rst=1 (edge 0);
//   inputs change 1ns after an edge, so they are first sampled at the
//   following edge.
module tb_reset_sequencer;
    localparam int N_OUT = 3;
    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int CNT_W = 8;

    // counter must hold the larger of the two programmed counts
    if ((HOLD > (2 ** CNT_W) - 1) || (GAP > (2 ** CNT_W) - 1)) begin : g_cnt_w_bad
        $fatal(1, "CNT_W too narrow for HOLD/GAP");
    end

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    reset_sequencer_if #(.N_OUT(N_OUT)) m ();
    reset_sequencer_if #(.N_OUT(1))     b ();

    reset_sequencer #(.N_OUT(N_OUT), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .CNT_W(CNT_W)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (m.slave)
    );

    reset_sequencer #(.N_OUT(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .CNT_W(CNT_W)) u_dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (b.slave)
    );

    int checks = 0;
    int errors = 0;
    int cur    = 0;
    bit mon_en = 1'b0;
    logic prev_done_m = 1'b0;
    logic prev_done_b = 1'b0;

    // every-cycle invariants on both instances
    always @(negedge Clk) begin
        if (mon_en) begin
            logic [N_OUT-1:0] x;
            x = ~m.Rst_o;
            checks++;
            if ((x & (x + 3'd1)) !== 3'd0) begin errors++; $display("FAIL thermo: Rst_o=%b", m.Rst_o); end
            checks++;
            if (m.Busy_o !== (|m.Rst_o)) begin errors++; $display("FAIL busy_m: got %b exp %b", m.Busy_o, |m.Rst_o); end
            checks++;
            if (b.Busy_o !== b.Rst_o[0]) begin errors++; $display("FAIL busy_b: got %b exp %b", b.Busy_o, b.Rst_o[0]); end
            checks++;
            if ((m.Done_o && prev_done_m) || (b.Done_o && prev_done_b)) begin
                errors++; $display("FAIL done_width: m=%b b=%b", m.Done_o, b.Done_o);
            end
            checks++;
            if ((m.Done_o && m.Rst_o !== 3'b000) || (b.Done_o && b.Rst_o !== 1'b0)) begin
                errors++; $display("FAIL done_rst: m=%b b=%b", m.Rst_o, b.Rst_o);
            end
            prev_done_m = m.Done_o;
            prev_done_b = b.Done_o;
        end
    end

    // Rst high for 3 edges; the third is edge 0
    task automatic do_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        cur = 0;
    endtask

    task automatic wait_edge(input int e);
        repeat (e - cur) @(posedge Clk);
        #1;
        cur = e;
    endtask

    task automatic test_reset();
        m.Lock_i = 1'b1; m.Req_i = 1'b0;
        b.Lock_i = 1'b1; b.Req_i = 1'b0;
        Rst = 1'b1;
        @(posedge Clk); #1;
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL rst_rsto: got %b exp 111", m.Rst_o); end
        checks++; if (m.Busy_o !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b exp 1", m.Busy_o); end
        checks++; if (m.Done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", m.Done_o); end
        checks++; if (b.Rst_o !== 1'b1 || b.Busy_o !== 1'b1 || b.Done_o !== 1'b0) begin
            errors++; $display("FAIL rst_b: got %b%b%b exp 110", b.Rst_o, b.Busy_o, b.Done_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_powerup();
        do_reset();
        wait_edge(15);
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL pu_e15: got %b exp 111", m.Rst_o); end
        wait_edge(16);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL pu_e16: got %b exp 110", m.Rst_o); end
        wait_edge(19);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL pu_e19: got %b exp 110", m.Rst_o); end
        wait_edge(20);
        checks++; if (m.Rst_o !== 3'b100) begin errors++; $display("FAIL pu_e20: got %b exp 100", m.Rst_o); end
        wait_edge(23);
        checks++; if (m.Rst_o !== 3'b100 || m.Busy_o !== 1'b1 || m.Done_o !== 1'b0) begin
            errors++; $display("FAIL pu_e23: got %b b%b d%b exp 100 b1 d0", m.Rst_o, m.Busy_o, m.Done_o);
        end
        wait_edge(24);
        checks++; if (m.Rst_o !== 3'b000 || m.Busy_o !== 1'b0 || m.Done_o !== 1'b1) begin
            errors++; $display("FAIL pu_e24: got %b b%b d%b exp 000 b0 d1", m.Rst_o, m.Busy_o, m.Done_o);
        end
        wait_edge(25);
        checks++; if (m.Done_o !== 1'b0 || m.Rst_o !== 3'b000) begin
            errors++; $display("FAIL pu_e25: got %b d%b exp 000 d0", m.Rst_o, m.Done_o);
        end
    endtask

    task automatic test_lock_gating();
        m.Lock_i = 1'b0;
        do_reset();
        wait_edge(10);
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL lk_e10: got %b exp 111", m.Rst_o); end
        m.Lock_i = 1'b1;
        wait_edge(25);
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL lk_e25: got %b exp 111", m.Rst_o); end
        wait_edge(26);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL lk_e26: got %b exp 110", m.Rst_o); end
        // lock drop mid-release
        do_reset();
        wait_edge(21);
        checks++; if (m.Rst_o !== 3'b100) begin errors++; $display("FAIL lk2_e21: got %b exp 100", m.Rst_o); end
        m.Lock_i = 1'b0;
        wait_edge(22);
        checks++; if (m.Rst_o !== 3'b111 || m.Busy_o !== 1'b1) begin
            errors++; $display("FAIL lk2_e22: got %b b%b exp 111 b1", m.Rst_o, m.Busy_o);
        end
        m.Lock_i = 1'b1;
        wait_edge(37);
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL lk2_e37: got %b exp 111", m.Rst_o); end
        wait_edge(38);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL lk2_e38: got %b exp 110", m.Rst_o); end
    endtask

    task automatic test_soft_req();
        do_reset();
        wait_edge(40);
        checks++; if (m.Rst_o !== 3'b000 || m.Busy_o !== 1'b0) begin
            errors++; $display("FAIL sr_e40: got %b b%b exp 000 b0", m.Rst_o, m.Busy_o);
        end
        m.Req_i = 1'b1;
        wait_edge(41);
        checks++; if (m.Rst_o !== 3'b111 || m.Busy_o !== 1'b1) begin
            errors++; $display("FAIL sr_e41: got %b b%b exp 111 b1", m.Rst_o, m.Busy_o);
        end
        wait_edge(45);
        m.Req_i = 1'b0;
        wait_edge(60);
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL sr_e60: got %b exp 111", m.Rst_o); end
        wait_edge(61);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL sr_e61: got %b exp 110", m.Rst_o); end
    endtask

    task automatic test_mid_rst();
        do_reset();
        wait_edge(18);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL mr_e18: got %b exp 110", m.Rst_o); end
        Rst = 1'b1;
        wait_edge(19);
        checks++; if (m.Rst_o !== 3'b111 || m.Done_o !== 1'b0 || m.Busy_o !== 1'b1) begin
            errors++; $display("FAIL mr_e19: got %b d%b b%b exp 111 d0 b1", m.Rst_o, m.Done_o, m.Busy_o);
        end
        Rst = 1'b0;
        cur = 0;  // edge 19 becomes the new edge 0
        wait_edge(15);
        checks++; if (m.Rst_o !== 3'b111) begin errors++; $display("FAIL mr_r15: got %b exp 111", m.Rst_o); end
        wait_edge(16);
        checks++; if (m.Rst_o !== 3'b110) begin errors++; $display("FAIL mr_r16: got %b exp 110", m.Rst_o); end
        wait_edge(20);
        checks++; if (m.Rst_o !== 3'b100) begin errors++; $display("FAIL mr_r20: got %b exp 100", m.Rst_o); end
        wait_edge(24);
        checks++; if (m.Rst_o !== 3'b000 || m.Done_o !== 1'b1) begin
            errors++; $display("FAIL mr_r24: got %b d%b exp 000 d1", m.Rst_o, m.Done_o);
        end
    endtask

    task automatic test_boundary();
        b.Lock_i = 1'b1; b.Req_i = 1'b0;
        do_reset();
        checks++; if (b.Rst_o !== 1'b1 || b.Busy_o !== 1'b1) begin
            errors++; $display("FAIL bd_e0: got %b b%b exp 1 b1", b.Rst_o, b.Busy_o);
        end
        wait_edge(1);
        checks++; if (b.Rst_o !== 1'b0 || b.Busy_o !== 1'b0 || b.Done_o !== 1'b1) begin
            errors++; $display("FAIL bd_e1: got %b b%b d%b exp 0 b0 d1", b.Rst_o, b.Busy_o, b.Done_o);
        end
        wait_edge(2);
        checks++; if (b.Rst_o !== 1'b0 || b.Done_o !== 1'b0) begin
            errors++; $display("FAIL bd_e2: got %b d%b exp 0 d0", b.Rst_o, b.Done_o);
        end
    endtask

    // random qualifiers on both instances; the N_OUT=1 corner is fully
    // predictable: one qualifying edge releases, any other edge re-asserts
    task automatic test_random();
        logic exp_rst, exp_done, q;
        do_reset();
        exp_rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            m.Lock_i = ($urandom_range(0, 15) != 0);
            m.Req_i  = ($urandom_range(0, 15) == 0);
            b.Lock_i = ($urandom_range(0, 3) != 0);
            b.Req_i  = ($urandom_range(0, 5) == 0);
            q = b.Lock_i & ~b.Req_i;
            @(posedge Clk); #1;
            exp_done = q & exp_rst;
            exp_rst  = ~q;
            checks++;
            if (b.Rst_o !== exp_rst || b.Done_o !== exp_done) begin
                errors++; $display("FAIL rnd_b[%0d]: got r%b d%b exp r%b d%b", i, b.Rst_o, b.Done_o, exp_rst, exp_done);
            end
        end
        m.Lock_i = 1'b1; m.Req_i = 1'b0;
        b.Lock_i = 1'b1; b.Req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_lock_gating();
        test_soft_req();
        test_mid_rst();
        test_boundary();
        test_random();
        @(posedge Clk); #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
